// File: rtl/riscv_lsu_if.sv
// Signal bundle between the riscv_lsu MEM stage, the EX/WB pipeline and the data-memory bus.
// master is the LSU's view; slave is the view of the surrounding pipeline and memory.
interface riscv_lsu_if #(
    parameter int XLEN = 32
);
    localparam int BE_W = XLEN / 8;

    logic            valid_i;
    logic            ready_o;
    logic            mem_read_i;
    logic            mem_write_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] alu_out_i;
    logic [XLEN-1:0] rs2_data_i;

    logic            req_o;
    logic            gnt_i;
    logic            we_o;
    logic [BE_W-1:0] be_o;
    logic [XLEN-1:0] addr_o;
    logic [XLEN-1:0] wdata_o;
    logic            rvalid_i;
    logic [XLEN-1:0] rdata_i;

    logic            valid_o;
    logic [XLEN-1:0] data_out_o;
    logic [XLEN-1:0] alu_out_o;
    logic            misalign_o;

    modport master (
        input  valid_i, mem_read_i, mem_write_i, funct3_i, alu_out_i, rs2_data_i,
        input  gnt_i, rvalid_i, rdata_i,
        output ready_o, req_o, we_o, be_o, addr_o, wdata_o,
        output valid_o, data_out_o, alu_out_o, misalign_o
    );

    modport slave (
        output valid_i, mem_read_i, mem_write_i, funct3_i, alu_out_i, rs2_data_i,
        output gnt_i, rvalid_i, rdata_i,
        input  ready_o, req_o, we_o, be_o, addr_o, wdata_o,
        input  valid_o, data_out_o, alu_out_o, misalign_o
    );
endinterface

// File: rtl/riscv_lsu.sv
// RISC-V MEM stage: one operation at a time over a req/gnt/rvalid bus with byte enables.
// Define RISCV_LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module riscv_lsu #(
    parameter int XLEN = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    riscv_lsu_if.master  bus
);
    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam logic [1:0] MAX_SZ = (XLEN == 64) ? 2'd3 : 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t state, state_nxt;

    logic             mem_op;
    logic             mis;
    logic             accept;
    logic [1:0]       sz;
    logic [OFF_W:0]   nbytes;
    logic [OFF_W-1:0] off_raw;
    logic [OFF_W-1:0] low_mask;
    logic [OFF_W-1:0] eff_off;

    logic [1:0]       sz_q;
    logic [OFF_W-1:0] off_q;
    logic             uns_q;

    function automatic logic [BE_W-1:0] lane_mask(input logic [OFF_W-1:0] off,
                                                   input logic [OFF_W:0]   nb);
        logic [BE_W-1:0] m;
        for (int i = 0; i < BE_W; i++)
            m[i] = (i >= int'(off)) && (i < int'(off) + int'(nb));
        return m;
    endfunction

    function automatic logic [XLEN-1:0] replicate(input logic [XLEN-1:0] d,
                                                  input logic [OFF_W:0]  nb);
        logic [XLEN-1:0] r;
        for (int i = 0; i < BE_W; i++)
            r[8*i +: 8] = d[8*(i & (int'(nb) - 1)) +: 8];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                               input logic [1:0]      size,
                                               input logic            uns);
        logic [XLEN-1:0] r;
        logic            fill;
        int              nbits;
        nbits = 8 << size;
        fill  = uns ? 1'b0 : raw[nbits-1];
        for (int i = 0; i < XLEN; i++)
            r[i] = (i < nbits) ? raw[i] : fill;
        return r;
    endfunction

    // Size/offset decode; D and WU collapse to W on a 32-bit datapath
    always_comb begin
        mem_op   = bus.mem_read_i | bus.mem_write_i;
        sz       = (bus.funct3_i[1:0] > MAX_SZ) ? MAX_SZ : bus.funct3_i[1:0];
        nbytes   = (OFF_W+1)'(1) << sz;
        low_mask = OFF_W'(nbytes - 1'b1);
        off_raw  = bus.alu_out_i[OFF_W-1:0];
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        mis      = mem_op && (((off_raw & low_mask) != '0) ||
                              (({1'b0, off_raw} + nbytes) > (OFF_W+1)'(BE_W)));
        eff_off  = off_raw;
`else
        mis      = 1'b0;
        eff_off  = off_raw & ~low_mask;
`endif
        accept   = (state == S_IDLE) && bus.valid_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bus.ready_o = 1'b0;
        bus.req_o   = 1'b0;
        case (state)
            S_IDLE: begin
                bus.ready_o = 1'b1;
                if (bus.valid_i && mem_op && !mis)
                    state_nxt = S_REQ;
            end
            S_REQ: begin
                bus.req_o = 1'b1;
                if (bus.gnt_i)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.rvalid_i)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus fields latch at accept and stay frozen through REQ/WAIT
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.we_o       <= 1'b0;
            bus.be_o       <= '0;
            bus.addr_o     <= '0;
            bus.wdata_o    <= '0;
            bus.valid_o    <= 1'b0;
            bus.data_out_o <= '0;
            bus.alu_out_o  <= '0;
            bus.misalign_o <= 1'b0;
            sz_q           <= '0;
            off_q          <= '0;
            uns_q          <= 1'b0;
        end else begin
            bus.valid_o <= 1'b0;
            if (accept) begin
                bus.alu_out_o <= bus.alu_out_i;
                if (!mem_op || mis) begin
                    bus.valid_o    <= 1'b1;
                    bus.data_out_o <= '0;
                    bus.misalign_o <= mis;
                end else begin
                    bus.we_o       <= bus.mem_write_i;
                    bus.be_o       <= lane_mask(eff_off, nbytes);
                    bus.addr_o     <= {bus.alu_out_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                    bus.wdata_o    <= replicate(bus.rs2_data_i, nbytes);
                    bus.misalign_o <= 1'b0;
                    sz_q           <= sz;
                    off_q          <= eff_off;
                    uns_q          <= bus.funct3_i[2];
                end
            end
            if ((state == S_WAIT) && bus.rvalid_i) begin
                bus.valid_o    <= 1'b1;
                bus.data_out_o <= bus.we_o ? '0
                                           : extend(bus.rdata_i >> {off_q, 3'b000}, sz_q, uns_q);
            end
        end
    end
endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu (XLEN=32): expected WB results are queued at issue and
// checked by a monitor whenever valid_o pulses.
module tb_riscv_lsu;
    localparam int XLEN = 32;

    typedef struct {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] alu;
        logic            mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   evaluated = 0;
    int   failures  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    riscv_lsu_if #(.XLEN(XLEN)) bus();

    riscv_lsu #(.XLEN(XLEN)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        evaluated++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] d);
        bus.valid_i     = 1'b1;
        bus.mem_read_i  = rd;
        bus.mem_write_i = wr;
        bus.funct3_i    = f3;
        bus.alu_out_i   = a;
        bus.rs2_data_i  = d;
        next_cycle();
        bus.valid_i     = 1'b0;
        bus.mem_read_i  = 1'b0;
        bus.mem_write_i = 1'b0;
    endtask

    // Grant now, respond on the following cycle, return in the cycle valid_o should pulse
    task automatic grant_respond(input logic [XLEN-1:0] rd);
        bus.gnt_i = 1'b1;
        next_cycle();
        bus.gnt_i    = 1'b0;
        bus.rvalid_i = 1'b1;
        bus.rdata_i  = rd;
        @(negedge clk);
        check("valid_early", bus.valid_o, 1'b0);
        next_cycle();
        bus.rvalid_i = 1'b0;
        @(negedge clk);
        check("valid_pulse", bus.valid_o, 1'b1);
        check("ready_back", bus.ready_o, 1'b1);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", bus.valid_o, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("data_out", bus.data_out_o, e.data);
                check("alu_out", bus.alu_out_o, e.alu);
                check("misalign", bus.misalign_o, e.mis);
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.valid_i     = 1'b0;
        bus.mem_read_i  = 1'b0;
        bus.mem_write_i = 1'b0;
        bus.funct3_i    = 3'b000;
        bus.alu_out_i   = '0;
        bus.rs2_data_i  = '0;
        bus.gnt_i       = 1'b0;
        bus.rvalid_i    = 1'b0;
        bus.rdata_i     = '0;

        @(negedge clk);
        check("rst_ready", bus.ready_o, 1'b1);
        check("rst_req", bus.req_o, 1'b0);
        check("rst_we", bus.we_o, 1'b0);
        check("rst_be", bus.be_o, 4'h0);
        check("rst_addr", bus.addr_o, 32'h0);
        check("rst_wdata", bus.wdata_o, 32'h0);
        check("rst_valid", bus.valid_o, 1'b0);
        check("rst_data", bus.data_out_o, 32'h0);
        check("rst_alu", bus.alu_out_o, 32'h0);
        check("rst_mis", bus.misalign_o, 1'b0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Non-memory pass-through
        sb.push_back('{data: 32'h0, alu: 32'h1234, mis: 1'b0});
        issue(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0);
        @(negedge clk);
        check("alu_valid", bus.valid_o, 1'b1);
        check("alu_noreq", bus.req_o, 1'b0);
        next_cycle();

        // LB signed at byte 3
        sb.push_back('{data: 32'hFFFF_FF80, alu: 32'h103, mis: 1'b0});
        issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
        @(negedge clk);
        check("lb_req", bus.req_o, 1'b1);
        check("lb_ready", bus.ready_o, 1'b0);
        check("lb_addr", bus.addr_o, 32'h100);
        check("lb_be", bus.be_o, 4'b1000);
        check("lb_we", bus.we_o, 1'b0);
        grant_respond(32'h80FF_FF7F);

        // LHU issued back-to-back in the valid_o cycle
        sb.push_back('{data: 32'h0000_8001, alu: 32'h12, mis: 1'b0});
        issue(1'b1, 1'b0, 3'b101, 32'h12, 32'h0);
        @(negedge clk);
        check("lhu_addr", bus.addr_o, 32'h10);
        check("lhu_be", bus.be_o, 4'b1100);
        grant_respond(32'h8001_1234);

        // SH to the upper half
        next_cycle();
        sb.push_back('{data: 32'h0, alu: 32'h22, mis: 1'b0});
        issue(1'b0, 1'b1, 3'b001, 32'h22, 32'hDEAD_BEEF);
        @(negedge clk);
        check("sh_req", bus.req_o, 1'b1);
        check("sh_we", bus.we_o, 1'b1);
        check("sh_be", bus.be_o, 4'b1100);
        check("sh_wdata", bus.wdata_o, 32'hBEEF_BEEF);
        check("sh_addr", bus.addr_o, 32'h20);
        grant_respond(32'h0);

        // SW with grant withheld for five cycles
        next_cycle();
        sb.push_back('{data: 32'h0, alu: 32'h40, mis: 1'b0});
        issue(1'b0, 1'b1, 3'b010, 32'h40, 32'h1122_3344);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_req", bus.req_o, 1'b1);
            check("stall_ready", bus.ready_o, 1'b0);
            check("stall_addr", bus.addr_o, 32'h40);
            check("stall_be", bus.be_o, 4'b1111);
            check("stall_wdata", bus.wdata_o, 32'h1122_3344);
            bus.rvalid_i = (c == 2);
            next_cycle();
            bus.rvalid_i = 1'b0;
        end
        grant_respond(32'h0);

        // Misaligned LW at 0x201
        next_cycle();
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        sb.push_back('{data: 32'h0, alu: 32'h201, mis: 1'b1});
        issue(1'b1, 1'b0, 3'b010, 32'h201, 32'h0);
        @(negedge clk);
        check("mis_noreq", bus.req_o, 1'b0);
        check("mis_valid", bus.valid_o, 1'b1);
        check("mis_flag", bus.misalign_o, 1'b1);
`else
        sb.push_back('{data: 32'hCAFE_F00D, alu: 32'h201, mis: 1'b0});
        issue(1'b1, 1'b0, 3'b010, 32'h201, 32'h0);
        @(negedge clk);
        check("mis_addr", bus.addr_o, 32'h200);
        check("mis_be", bus.be_o, 4'b1111);
        grant_respond(32'hCAFE_F00D);
`endif

        // Reset while waiting for the response
        next_cycle();
        issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
        bus.gnt_i = 1'b1;
        next_cycle();
        bus.gnt_i = 1'b0;
        check("wait_ready", bus.ready_o, 1'b0);
        rst = 1'b1;
        #1;
        check("rstw_req", bus.req_o, 1'b0);
        check("rstw_ready", bus.ready_o, 1'b1);
        next_cycle();
        rst          = 1'b0;
        bus.rvalid_i = 1'b1;
        bus.rdata_i  = 32'h5555_AAAA;
        next_cycle();
        bus.rvalid_i = 1'b0;
        @(negedge clk);
        check("rstw_novalid", bus.valid_o, 1'b0);
        next_cycle();
        next_cycle();

        check("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end
endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Parametrised load/store unit forming the MEM stage of the RISC-V pipeline, between EX and WB. It accepts one operation per handshake from EX and drives a request/grant/response data-memory bus with byte enables. Loads are returned sign- or zero-extended, and non-memory ALU results pass straight through. It generalises the single-width MEM stage to XLEN 32/64, sub-word accesses, a stalling bus handshake and misalignment detection.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- BE_W, XLEN/8, byte-enable width (derived, do not override)
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- valid_i  in  1  EX presents an operation
- ready_o  out  1  LSU accepts the operation this cycle (stall to EX when 0)
- mem_read_i  in  1  operation is a load
- mem_write_i  in  1  operation is a store (mem_read_i and mem_write_i never both 1)
- funct3_i  in  3  access size and sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- alu_out_i  in  XLEN  effective address, or the ALU result for non-memory operations
- rs2_data_i  in  XLEN  store data
- req_o  out  1  bus request
- gnt_i  in  1  bus grant; the request completes in the cycle where req_o&gnt_i
- we_o  out  1  store when 1
- be_o  out  BE_W  byte lanes
- addr_o  out  XLEN  word-aligned address (low log2(BE_W) bits 0)
- wdata_o  out  XLEN  lane-replicated store data
- rvalid_i  in  1  response; earliest in the cycle after the grant
- rdata_i  in  XLEN  load data, valid with rvalid_i
- valid_o  out  1  one-cycle pulse: result to WB
- data_out_o  out  XLEN  extended load data (0 for stores and non-memory operations)
- alu_out_o  out  XLEN  registered copy of alu_out_i for the accepted operation
- misalign_o  out  1  accepted access was misaligned (valid with valid_o)

## Operation
- Reset values of every output: ready_o=1, req_o=0, we_o=0, be_o=0, addr_o=0, wdata_o=0, valid_o=0, data_out_o=0, alu_out_o=0, misalign_o=0. The FSM resets to IDLE.
- FSM states:
  - IDLE: ready_o=1. The accept condition is valid_i.
  - On accept of a non-memory operation: stay in IDLE and pulse valid_o next cycle.
  - On accept of a memory operation: go to REQ. The request fields are registered at this point.
  - REQ: req_o=1, ready_o=0. Hold all bus fields stable until gnt_i, then go to WAIT.
  - WAIT: req_o=0. On rvalid_i, pulse valid_o next cycle with the result, then go to IDLE.
  - Stores also wait for rvalid_i as their acknowledge.
- Access size comes from funct3_i[1:0]: 1, 2, 4 or 8 bytes. offset = alu_out_i[log2(BE_W)-1:0].
- be_o is the size mask shifted left by offset.
- wdata_o replicates rs2_data_i's low size bytes across every lane.
- Load result is rdata_i >> (8*offset), truncated to size, then extended:
  - funct3_i[2]=0: sign-extend.
  - funct3_i[2]=1: zero-extend.
- D and WU with XLEN=32 are decoded as W.
- Only one operation is outstanding at a time. WB never back-pressures.

## Timing
- Non-memory operation accepted in cycle T: valid_o is 1 in T+1.
- Memory operation accepted in T: req_o is 1 from T+1.
  - Grant in cycle G: rvalid_i is no earlier than G+1.
  - rvalid_i in cycle R: valid_o is 1 in R+1.
  - Minimum load/store latency is 3 cycles (T to T+3).
- ready_o returns to 1 in the same cycle valid_o pulses. Back-to-back accept in that cycle is legal.
- rvalid_i outside WAIT is ignored.
- gnt_i while req_o=0 is ignored.
- Reset mid-transaction: outputs return to reset values immediately (asynchronous). Any response in flight is dropped.

## Configuration
- RISCV_LSU_MISALIGN_TRAP_EN defined: misalignment is detected and trapped.
  - An access is misaligned if offset is not a multiple of size, or if offset+size > BE_W.
  - A misaligned access issues no bus request.
  - valid_o is 1 in T+1 with misalign_o=1 and data_out_o=0.
- Undefined: misalign_o is tied 0.
  - The access uses offset aligned down to a multiple of size.
  - The low address bits below size are treated as 0.

## Test plan
- Non-memory pass-through: valid_i=1, mem_read_i=mem_write_i=0, alu_out_i=0x1234 at T -> valid_o=1, alu_out_o=0x1234, data_out_o=0 at T+1, with no req_o.
- LB with sign: XLEN=32, addr 0x103, rdata_i=0x80FF_FF7F -> addr_o=0x100, be_o=4'b1000, data_out_o=0xFFFF_FF80.
- SH to upper half: addr 0x22, rs2_data_i=0xDEAD_BEEF -> be_o=4'b1100, wdata_o=0xBEEF_BEEF, we_o=1.
- Grant stall: gnt_i held 0 for 5 cycles -> req_o, addr_o, be_o and wdata_o stay stable and ready_o=0 throughout. Grant in the 6th cycle followed by rvalid_i on the next cycle -> valid_o one cycle after rvalid_i.
- Misaligned LW at 0x201 with the macro defined -> no req_o, and valid_o=1, misalign_o=1 at T+1. Without the macro -> addr_o=0x200, be_o=4'b1111.
- rst_i asserted while in WAIT -> req_o=0 and ready_o=1 immediately. A following rvalid_i produces no valid_o.
